// File: rtl/rr_arb_if.sv
// Request/grant bundle between client request lines and the 4-way arbiter.
interface rr_arb_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 clients; owner holds grant until it drops req.
// Optional forced release after TIMEOUT_CYCLES via `define ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    rr_arb_if.slave  arb
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    generate
        if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
            $error("CNT_W too small for TIMEOUT_CYCLES");
        end
    endgenerate

    state_t     state, state_n;
    logic [3:0] gnt_q, gnt_n;
    logic [1:0] idx_q, idx_n;
    logic       vld_q, vld_n;
    logic [1:0] ptr_q, ptr_n;
    logic [1:0] win;
    logic       forced;

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {r, r} >> p;
        rot = dbl[3:0];
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else             off = 2'd3;
        return p + off;
    endfunction

    assign win = pick(arb.req, ptr_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             to_q;

    // Only preempt the owner when someone else is actually waiting.
    assign forced = (state == GRANT) &&
                    arb.req[idx_q] &&
                    (cnt_q == CNT_LAST) &&
                    (|(arb.req & ~gnt_q));

    always_comb begin
        cnt_n = cnt_q;
        if (state == IDLE) begin
            cnt_n = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_n = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            to_q  <= forced;
        end
    end

    assign arb.timeout = to_q;
`else
    assign forced      = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        idx_n   = idx_q;
        vld_n   = vld_q;
        ptr_n   = ptr_q;
        unique case (state)
            IDLE: begin
                gnt_n = 4'b0000;
                idx_n = 2'd0;
                vld_n = 1'b0;
                if (|arb.req) begin
                    gnt_n   = 4'b0001 << win;
                    idx_n   = win;
                    vld_n   = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!arb.req[idx_q] || forced) begin
                    gnt_n   = 4'b0000;
                    idx_n   = 2'd0;
                    vld_n   = 1'b0;
                    ptr_n   = idx_q + 2'd1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_q <= 4'b0000;
            idx_q <= 2'd0;
            vld_q <= 1'b0;
            ptr_q <= 2'd0;
        end else begin
            state <= state_n;
            gnt_q <= gnt_n;
            idx_q <= idx_n;
            vld_q <= vld_n;
            ptr_q <= ptr_n;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: grant events checked by a scoreboard monitor.
// Builds with or without ARB_TIMEOUT_EN (TIMEOUT_CYCLES=4).
module tb_rr_arbiter_4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arb_if arb ();

    rr_arbiter_4 #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arb(arb)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_m;
    logic       prev_vld = 1'b0;
    logic [1:0] order[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new grant pops the next expected owner.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && arb.gnt_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got idx %0d expected none",
                         arb.gnt_idx);
            end else begin
                exp_m = exp_q.pop_front();
                chk("grant_idx", 32'(arb.gnt_idx), 32'(exp_m));
                chk("grant_onehot", 32'(arb.gnt), 32'(4'b0001 << exp_m));
            end
        end
        chk("inv_valid", 32'(arb.gnt_valid), 32'(|arb.gnt));
        chk("inv_onehot0", 32'($onehot0(arb.gnt)), 32'd1);
        if (!arb.gnt_valid)
            chk("inv_idx_zero", 32'(arb.gnt_idx), 32'd0);
        prev_vld = arb.gnt_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int k = 0;
        while (!arb.gnt_valid && k < budget) begin
            cyc(1);
            k++;
        end
        if (!arb.gnt_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: got no grant expected one within %0d cycles",
                     budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset with all clients requesting
        rst_n   = 1'b0;
        arb.req = 4'b1111;
        cyc(2);
        @(negedge clk);
        chk("rst_gnt", 32'(arb.gnt), 32'd0);
        chk("rst_idx", 32'(arb.gnt_idx), 32'd0);
        chk("rst_valid", 32'(arb.gnt_valid), 32'd0);
        chk("rst_timeout", 32'(arb.timeout), 32'd0);
        cyc(1);
        rst_n   = 1'b1;
        arb.req = 4'b0000;
        cyc(2);
        chk("idle_no_req", 32'(arb.gnt), 32'd0);

        // Single requester
        exp_q.push_back(2'd2);
        arb.req = 4'b0100;
        cyc(1);
        chk("single_gnt", 32'(arb.gnt), 32'h4);
        chk("single_idx", 32'(arb.gnt_idx), 32'd2);
        cyc(2);
        arb.req = 4'b0000;
        cyc(1);
        chk("single_release", 32'(arb.gnt), 32'd0);

        // Rotation from ptr 0 with everyone requesting
        do_reset();
        foreach (order[i]) exp_q.push_back(order[i]);
        arb.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(4);
            cyc(2);
            arb.req = 4'b1111 & ~(4'b0001 << order[i]);
            cyc(1);
            chk("rot_release", 32'(arb.gnt_valid), 32'd0);
            arb.req = (i == 4) ? 4'b0000 : 4'b1111;
        end

        // Owner 3 releases, ptr wraps to 0
        cyc(1);
        exp_q.push_back(2'd3);
        arb.req = 4'b1000;
        wait_grant(4);
        chk("wrap_owner", 32'(arb.gnt_idx), 32'd3);
        arb.req = 4'b1001;
        cyc(2);
        chk("wrap_ignore", 32'(arb.gnt_idx), 32'd3);
        exp_q.push_back(2'd0);
        arb.req = 4'b0001;
        cyc(1);
        chk("wrap_release", 32'(arb.gnt_valid), 32'd0);
        cyc(1);
        chk("wrap_idx", 32'(arb.gnt_idx), 32'd0);
        arb.req = 4'b0000;
        cyc(2);

        // Mid-grant reset drops grant at once and rewinds ptr
        exp_q.push_back(2'd1);
        arb.req = 4'b0010;
        wait_grant(4);
        chk("mid_owner", 32'(arb.gnt), 32'h2);
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(arb.gnt), 32'd0);
        chk("mid_rst_valid", 32'(arb.gnt_valid), 32'd0);
        cyc(1);
        exp_q.push_back(2'd0);
        rst_n   = 1'b1;
        arb.req = 4'b0011;
        cyc(1);
        chk("post_rst_idx", 32'(arb.gnt_idx), 32'd0);
        chk("post_rst_valid", 32'(arb.gnt_valid), 32'd1);
        arb.req = 4'b0000;
        cyc(2);

        // Contended hold: timeout forces handover after 4 cycles
        do_reset();
        exp_q.push_back(2'd0);
        arb.req = 4'b0011;
        cyc(1);
        chk("hold_gnt", 32'(arb.gnt), 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("hold_gnt", 32'(arb.gnt), 32'h1);
            chk("hold_timeout", 32'(arb.timeout), 32'd0);
        end
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back(2'd1);
        cyc(1);
        chk("to_release_gnt", 32'(arb.gnt), 32'd0);
        chk("to_pulse", 32'(arb.timeout), 32'd1);
        cyc(1);
        chk("to_next_gnt", 32'(arb.gnt), 32'h2);
        chk("to_pulse_end", 32'(arb.timeout), 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("nto_hold_gnt", 32'(arb.gnt), 32'h1);
            chk("nto_timeout", 32'(arb.timeout), 32'd0);
        end
`endif
        arb.req = 4'b0000;
        cyc(2);

        // Uncontended owner keeps grant past the timeout window
        exp_q.push_back(2'd0);
        arb.req = 4'b0001;
        cyc(1);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("solo_hold_gnt", 32'(arb.gnt), 32'h1);
            chk("solo_timeout", 32'(arb.timeout), 32'd0);
        end
        arb.req = 4'b0000;
        cyc(2);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
